// File: rtl/orb_packer_mc.sv
// orb_packer_mc - multi-channel orbit word packer.
// Captures bytes from N_CH strobed serial decoders, formats each into an
// OW-bit orbit word and writes it, channel-interleaved, into the shared orbit
// RAM through one round-robin arbitrated write port.
//
// Ports:
//   clk, rst   clock; asynchronous active-low reset
//   i_data     N_CH*DW  channel c byte at [c*DW +: DW]
//   i_strob    N_CH     per-channel byte strobe (asynchronous level)
//   sw         frame-switch input (asynchronous), any toggle = resync
//   o_word     RAM write data
//   o_addr     RAM write address
//   o_we       RAM write enable, 1-cycle pulse
//   o_ch       channel owning the current write (1 bit wide, 0, when N_CH=1)
//   o_resync   1-cycle pulse on each sw toggle
//   o_ovf      sticky per channel: strobe lost while a capture was in flight
//
// Build option: ORB_PARITY_EN - when defined, o_word MSB carries odd parity
// of the data byte; otherwise it is 0.

// Per-channel capture FSM: IDLE -> HOLD (settle) -> REQ (arbitrate) -> WAIT.
module orb_packer_ch #(
  parameter int N_CH        = 2,
  parameter int DW          = 8,
  parameter int OW          = 12,
  parameter int AW          = 11,
  parameter int WORDS_PK    = 16,
  parameter int STROBES_PK  = 20,
  parameter int STRIDE_LOG2 = 5,
  parameter int WE_DELAY    = 30,
  parameter int CH          = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobS,   // synchronised strobe
  input  logic [DW-1:0] data,
  input  logic          resync,
  input  logic          grant,
  output logic          req,
  output logic [OW-1:0] word,
  output logic [AW-1:0] addr,
  output logic          ovf
);
  localparam int PW = AW - STRIDE_LOG2;
  localparam logic [5:0] WORDS_L = 6'(WORDS_PK);
  localparam logic [5:0] LAST_L  = 6'(STROBES_PK - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REQ, WAIT} state_t;
  state_t state, stateNx;

  logic [5:0]    slot;
  logic [PW-1:0] pack;
  logic [7:0]    dly;
  logic          sawLow;   // strobe dropped since capture; a new rise is a lost byte
  logic          msb;
  logic          slotData;
  logic [AW-1:0] addrCap;

`ifdef ORB_PARITY_EN
  assign msb = ~^data;
`else
  assign msb = 1'b0;
`endif

  assign slotData = (slot < WORDS_L);
  assign addrCap  = {pack, {STRIDE_LOG2{1'b0}}} + AW'(slot) * AW'(N_CH) + AW'(CH);
  assign req      = (state == REQ);

  always_comb begin
    stateNx = state;
    case (state)
      IDLE: if (strobS) stateNx = slotData ? HOLD : WAIT;
      HOLD: if (dly == 8'd1) stateNx = REQ;
      REQ:  if (grant) stateNx = WAIT;
      WAIT: if (!strobS) stateNx = IDLE;
      default: stateNx = IDLE;
    endcase
    if (resync) stateNx = WAIT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      slot   <= '0;
      pack   <= '0;
      dly    <= '0;
      word   <= '0;
      addr   <= '0;
      ovf    <= 1'b0;
      sawLow <= 1'b0;
    end else begin
      state <= stateNx;
      if (resync) begin
        slot   <= '0;
        pack   <= '0;
        sawLow <= 1'b0;
      end else begin
        if (state == IDLE) begin
          sawLow <= 1'b0;
          if (strobS) begin
            if (slotData) begin
              word <= OW'({msb, data}) << (OW - DW - 1);
              addr <= addrCap;
              dly  <= 8'(WE_DELAY);
            end
            // wrap check on both paths so WORDS_PK == STROBES_PK still wraps
            if (slot == LAST_L) begin
              slot <= '0;
              pack <= pack + 1'b1;
            end else begin
              slot <= slot + 1'b1;
            end
          end
        end else begin
          if (state == HOLD) dly <= dly - 1'b1;
          if (!strobS) sawLow <= 1'b1;
          else if (sawLow) begin
            ovf    <= 1'b1;
            sawLow <= 1'b0;
          end
        end
      end
    end
  end
endmodule

module orb_packer_mc #(
  parameter int N_CH        = 2,
  parameter int DW          = 8,
  parameter int OW          = 12,
  parameter int AW          = 11,
  parameter int WORDS_PK    = 16,
  parameter int STROBES_PK  = 20,
  parameter int STRIDE_LOG2 = 5,
  parameter int WE_DELAY    = 30,
  localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH*DW-1:0] i_data,
  input  logic [N_CH-1:0]    i_strob,
  input  logic               sw,
  output logic [OW-1:0]      o_word,
  output logic [AW-1:0]      o_addr,
  output logic               o_we,
  output logic [CW-1:0]      o_ch,
  output logic               o_resync,
  output logic [N_CH-1:0]    o_ovf
);
  logic [N_CH-1:0]          strobS0, strobS1;
  logic                     swS0, swS1, oldSw, resync;
  logic [N_CH-1:0]          req, gnt;
  logic [N_CH-1:0][OW-1:0]  chWord;
  logic [N_CH-1:0][AW-1:0]  chAddr;
  logic [CW-1:0]            ptr, gntIdx;
  logic                     gntVld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobS0 <= '0;
      strobS1 <= '0;
      swS0    <= 1'b0;
      swS1    <= 1'b0;
      oldSw   <= 1'b0;
    end else begin
      strobS0 <= i_strob;
      strobS1 <= strobS0;
      swS0    <= sw;
      swS1    <= swS0;
      oldSw   <= swS1;
    end
  end

  assign resync = swS1 ^ oldSw;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    orb_packer_ch #(
      .N_CH(N_CH), .DW(DW), .OW(OW), .AW(AW), .WORDS_PK(WORDS_PK),
      .STROBES_PK(STROBES_PK), .STRIDE_LOG2(STRIDE_LOG2),
      .WE_DELAY(WE_DELAY), .CH(c)
    ) u_ch (
      .clk(clk), .rst(rst), .strobS(strobS1[c]), .data(i_data[c*DW +: DW]),
      .resync(resync), .grant(gnt[c]), .req(req[c]),
      .word(chWord[c]), .addr(chAddr[c]), .ovf(o_ovf[c])
    );
  end

  // First requester at or after the rotating pointer; resync suppresses grants.
  always_comb begin
    gntVld = 1'b0;
    gntIdx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!gntVld && req[(int'(ptr) + i) % N_CH]) begin
        gntVld = 1'b1;
        gntIdx = CW'((int'(ptr) + i) % N_CH);
      end
    end
    if (resync) gntVld = 1'b0;
    gnt = gntVld ? (N_CH'(1) << gntIdx) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_word   <= '0;
      o_addr   <= '0;
      o_we     <= 1'b0;
      o_ch     <= '0;
      o_resync <= 1'b0;
      ptr      <= '0;
    end else begin
      o_we     <= gntVld;
      o_resync <= resync;
      if (gntVld) begin
        o_word <= chWord[gntIdx];
        o_addr <= chAddr[gntIdx];
        o_ch   <= gntIdx;
        ptr    <= (gntIdx == CW'(N_CH - 1)) ? '0 : gntIdx + 1'b1;
      end
    end
  end
endmodule
